// File: rtl/button_conditioner.sv
// Push-button front end: 2-FF synchronizer, per-button debounce, rise/fall pulses.
// Optional long-press pulse when BTN_LONG_PRESS_EN is defined.
module button_conditioner #(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] rise_button,
  output logic [N_BTN-1:0] fall_button,
  output logic [N_BTN-1:0] long_button
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : gen_param_check
    $error("button_conditioner: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
  end

  logic [N_BTN-1:0] sync1_q, s2_q;
  logic [N_BTN-1:0] stable_q, stable_d;
  logic [N_BTN-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [CntW-1:0]  cnt_q [N_BTN];
  logic [CntW-1:0]  cnt_d [N_BTN];

  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
        rise_d[i]   = s2_q[i];
        fall_d[i]   = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int i = 0; i < int'(N_BTN); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= btn_raw ^ {N_BTN{ACTIVE_LOW}};
      s2_q     <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      for (int i = 0; i < int'(N_BTN); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_level   = stable_q;
  assign rise_button = rise_q;
  assign fall_button = fall_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_CYCLES);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

  logic [HoldW-1:0] hold_q [N_BTN];
  logic [HoldW-1:0] hold_d [N_BTN];
  logic [N_BTN-1:0] long_q, long_d;

  // Saturating at HoldMax is what prevents a repeat until release.
  always_comb begin
    long_d = '0;
    for (int i = 0; i < int'(N_BTN); i++) begin
      hold_d[i] = hold_q[i];
      if (!stable_q[i]) begin
        hold_d[i] = '0;
      end else if (hold_q[i] != HoldMax) begin
        hold_d[i] = hold_q[i] + HoldW'(1);
        long_d[i] = (hold_q[i] == HoldLast);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      long_q <= '0;
      for (int i = 0; i < int'(N_BTN); i++) hold_q[i] <= '0;
    end else begin
      long_q <= long_d;
      for (int i = 0; i < int'(N_BTN); i++) hold_q[i] <= hold_d[i];
    end
  end

  assign long_button = long_q;
`else
  assign long_button = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
// A second instance with ACTIVE_LOW=1 covers inverted inputs.
module tb_button_conditioner;

  localparam int unsigned NB = 5;
`ifdef BTN_LONG_PRESS_EN
  localparam bit LongEn = 1'b1;
`else
  localparam bit LongEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] raw = '0;
  logic [NB-1:0] raw_al = 5'b11111;
  logic [NB-1:0] level, rise, fall, lng;
  logic [NB-1:0] al_level, al_rise, al_fall, al_long;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(raw), .btn_level(level),
    .rise_button(rise), .fall_button(fall), .long_button(lng)
  );

  button_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .reset(reset), .btn_raw(raw_al), .btn_level(al_level),
    .rise_button(al_rise), .fall_button(al_fall), .long_button(al_long)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [NB-1:0] lv, input logic [NB-1:0] r,
                            input logic [NB-1:0] f, input logic [NB-1:0] lg);
    check({tag, "_level"}, 32'(level), 32'(lv));
    check({tag, "_rise"}, 32'(rise), 32'(r));
    check({tag, "_fall"}, 32'(fall), 32'(f));
    check({tag, "_long"}, 32'(lng), 32'(lg));
  endtask

  // Raw already set before the next edge (E0); the event lands on tick 6 (E0+5).
  task automatic run_event(input string tag, input logic [NB-1:0] lv_before,
                           input logic [NB-1:0] lv_after, input logic [NB-1:0] r,
                           input logic [NB-1:0] f);
    for (int t = 1; t <= 5; t++) begin
      tick();
      check_outs({tag, "_wait"}, lv_before, '0, '0, '0);
    end
    tick();
    check_outs({tag, "_evt"}, lv_after, r, f, '0);
    tick();
    check_outs({tag, "_after"}, lv_after, '0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check_outs("reset", '0, '0, '0, '0);
    check("reset_al_level", 32'(al_level), 32'h0);
    reset = 1'b0;

    // Clean press and release of bit 1
    raw = 5'b00010;
    run_event("press1", 5'b00000, 5'b00010, 5'b00010, 5'b00000);
    raw = 5'b00000;
    run_event("rel1", 5'b00010, 5'b00000, 5'b00000, 5'b00010);

    // Bounce on bit 0: high 3, low 1, high 2, then low; nothing must be accepted
    begin
      logic [9:0] pat;
      pat = 10'b1110110000;
      for (int t = 9; t >= 0; t--) begin
        raw = {4'b0000, pat[t]};
        tick();
        check_outs("bounce", '0, '0, '0, '0);
      end
    end
    raw = 5'b00001;
    run_event("bounce_hold", 5'b00000, 5'b00001, 5'b00001, 5'b00000);
    for (int t = 1; t <= 3; t++) begin
      tick();
      check_outs("bounce_held", 5'b00001, '0, '0, '0);
    end
    raw = 5'b00000;
    run_event("bounce_rel", 5'b00001, 5'b00000, 5'b00000, 5'b00001);

    // Simultaneous press and release of bits 2 and 4
    raw = 5'b10100;
    run_event("simul_press", 5'b00000, 5'b10100, 5'b10100, 5'b00000);
    raw = 5'b00000;
    run_event("simul_rel", 5'b10100, 5'b00000, 5'b00000, 5'b10100);

    // Reset 2 cycles into a bit-3 press, input held through reset
    raw = 5'b01000;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_outs("rst_mid", '0, '0, '0, '0);
    tick();
    check_outs("rst_mid2", '0, '0, '0, '0);
    reset = 1'b0;
    run_event("rst_rec", 5'b00000, 5'b01000, 5'b01000, 5'b00000);

    // Reset while pressed clears the level asynchronously, then re-press
    reset = 1'b1;
    #1;
    check("rst_async_level", 32'(level), 32'h0);
    tick();
    reset = 1'b0;
    run_event("rst_repress", 5'b00000, 5'b01000, 5'b01000, 5'b00000);
    raw = 5'b00000;
    run_event("rel3", 5'b01000, 5'b00000, 5'b00000, 5'b01000);

    // Long press on bit 1: held 40 cycles
    raw = 5'b00010;
    for (int t = 1; t <= 47; t++) begin
      tick();
      check_outs($sformatf("long_t%0d", t),
                 (t >= 6 && t <= 45) ? 5'b00010 : 5'b00000,
                 (t == 6) ? 5'b00010 : 5'b00000,
                 (t == 46) ? 5'b00010 : 5'b00000,
                 (LongEn && t == 26) ? 5'b00010 : 5'b00000);
      if (t == 40) raw = 5'b00000;
    end

    // Active-low instance: idle-high inputs gave no events; press bit 1 by driving 0
    check("al_idle_level", 32'(al_level), 32'h0);
    check("al_idle_rise", 32'(al_rise), 32'h0);
    raw_al = 5'b11101;
    for (int t = 1; t <= 7; t++) begin
      tick();
      check($sformatf("al_rise_t%0d", t), 32'(al_rise), (t == 6) ? 32'h2 : 32'h0);
      check($sformatf("al_level_t%0d", t), 32'(al_level), (t >= 6) ? 32'h2 : 32'h0);
      check($sformatf("al_fall_t%0d", t), 32'(al_fall | al_long), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
